mem_refill_arbiter: RTL and testbench

// - Shares the single external memory port between I-cache line refills
//   (read only) and D-cache refills and writebacks (read and write).
// - Sits below both caches. While a requester waits, its cache holds

---
 rtl/mem_refill_arbiter_pkg.sv | 16 +
 rtl/mem_refill_arbiter_picker.sv | 38 +++
 rtl/mem_refill_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_refill_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_refill_arbiter_pkg.sv
// Shared types for the memory refill arbiter: FSM states and owner encoding.
package mem_refill_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RD_BURST,
    WR_BURST
  } mem_arb_state_t;

  typedef enum logic {
    OWNER_IC,
    OWNER_DC
  } mem_owner_t;

endpackage

// File: rtl/mem_refill_arbiter_picker.sv
// Combinational owner picker for the memory refill arbiter.
// Build option: MEM_ARB_FAIR_EN selects round-robin between the two caches;
// when undefined the D-cache has fixed priority on a tie.
module mem_arb_picker
  import mem_refill_arbiter_pkg::*;
(
  input  logic       ic_valid,
  input  logic       dc_valid,
  input  mem_owner_t last_owner,
  output logic       grant_valid,
  output mem_owner_t grant_owner
);

`ifndef MEM_ARB_FAIR_EN
  // last_owner only matters for round-robin; keep it visibly consumed.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

  // Choose which requester owns the next burst.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant_valid = ic_valid | dc_valid;
    grant_owner = OWNER_IC;
`ifdef MEM_ARB_FAIR_EN
    if (ic_valid && dc_valid) begin
      grant_owner = (last_owner == OWNER_IC) ? OWNER_DC : OWNER_IC;
    end else if (dc_valid) begin
      grant_owner = OWNER_DC;
    end
`else
    if (dc_valid) begin
      grant_owner = OWNER_DC;
    end
`endif
  end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Shares one external memory port between I-cache refills and D-cache
// refills/writebacks, one line burst at a time.
// Build option: MEM_ARB_FAIR_EN (round-robin instead of D-cache priority),
// handled entirely inside mem_arb_picker.
module mem_refill_arbiter
  import mem_refill_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 26,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_rdata_valid,
  input  logic              dc_req_valid,
  input  logic              dc_req_write,
  input  logic [ADDR_W-1:0] dc_req_addr,
  output logic              dc_req_ready,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wdata_ready,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_rdata_valid,
  output logic              mem_req_valid,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_valid,
  input  logic              mem_wdata_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid,
  output logic              busy
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  mem_arb_state_t    state_q, state_d;
  mem_owner_t        owner_q, owner_d;
  mem_owner_t        last_owner_q, last_owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic       grant_valid;
  mem_owner_t grant_owner;

  mem_arb_picker u_picker (
    .ic_valid    (ic_req_valid),
    .dc_valid    (dc_req_valid),
    .last_owner  (last_owner_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_IC;
      last_owner_q <= OWNER_IC;
      addr_q       <= '0;
      write_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state: grant, hold request, count beats, return to IDLE after last beat.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    write_d      = write_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d      = grant_owner;
          last_owner_d = grant_owner;
          if (grant_owner == OWNER_DC) begin
            addr_d  = dc_req_addr;
            write_d = dc_req_write;
          end else begin
            addr_d  = ic_req_addr;
            write_d = 1'b0;
          end
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = write_q ? WR_BURST : RD_BURST;
        end
      end
      RD_BURST: begin
        if (mem_rdata_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = IDLE;
        end
      end
      WR_BURST: begin
        if (mem_wdata_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: grant pulses, request presentation and beat steering by state.
  always_comb begin
    ic_req_ready    = 1'b0;
    dc_req_ready    = 1'b0;
    ic_rdata        = '0;
    ic_rdata_valid  = 1'b0;
    dc_rdata        = '0;
    dc_rdata_valid  = 1'b0;
    dc_wdata_ready  = 1'b0;
    mem_req_valid   = 1'b0;
    mem_req_write   = 1'b0;
    mem_req_addr    = '0;
    mem_wdata       = '0;
    mem_wdata_valid = 1'b0;
    busy            = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        // A grant made while reset is asserted would not be latched, so suppress it.
        ic_req_ready = rst_n && grant_valid && (grant_owner == OWNER_IC);
        dc_req_ready = rst_n && grant_valid && (grant_owner == OWNER_DC);
      end
      REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = write_q;
        mem_req_addr  = addr_q;
      end
      RD_BURST: begin
        if (owner_q == OWNER_IC) begin
          ic_rdata       = mem_rdata;
          ic_rdata_valid = mem_rdata_valid;
        end else begin
          dc_rdata       = mem_rdata;
          dc_rdata_valid = mem_rdata_valid;
        end
      end
      WR_BURST: begin
        mem_wdata       = dc_wdata;
        mem_wdata_valid = 1'b1;
        dc_wdata_ready  = mem_wdata_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Self-checking bench for mem_refill_arbiter. The bench acts as both caches
// and the memory; a transaction-level model predicts grants and beat routing.
module tb_mem_refill_arbiter;

  localparam int A  = 26;
  localparam int D  = 32;
  localparam int LW = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ic_req_valid;
  logic [A-1:0] ic_req_addr;
  logic         ic_req_ready;
  logic [D-1:0] ic_rdata;
  logic         ic_rdata_valid;
  logic         dc_req_valid;
  logic         dc_req_write;
  logic [A-1:0] dc_req_addr;
  logic         dc_req_ready;
  logic [D-1:0] dc_wdata;
  logic         dc_wdata_ready;
  logic [D-1:0] dc_rdata;
  logic         dc_rdata_valid;
  logic         mem_req_valid;
  logic         mem_req_write;
  logic [A-1:0] mem_req_addr;
  logic         mem_req_ready;
  logic [D-1:0] mem_wdata;
  logic         mem_wdata_valid;
  logic         mem_wdata_ready;
  logic [D-1:0] mem_rdata;
  logic         mem_rdata_valid;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: outstanding requests per cache and who won the last grant.
  bit           ic_pend, dc_pend, dc_w;
  logic [A-1:0] ic_a, dc_a;
  bit           last_dc;

  mem_refill_arbiter #(.ADDR_W(A), .DATA_W(D), .LINE_WORDS(LW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ic_req_valid    (ic_req_valid),
    .ic_req_addr     (ic_req_addr),
    .ic_req_ready    (ic_req_ready),
    .ic_rdata        (ic_rdata),
    .ic_rdata_valid  (ic_rdata_valid),
    .dc_req_valid    (dc_req_valid),
    .dc_req_write    (dc_req_write),
    .dc_req_addr     (dc_req_addr),
    .dc_req_ready    (dc_req_ready),
    .dc_wdata        (dc_wdata),
    .dc_wdata_ready  (dc_wdata_ready),
    .dc_rdata        (dc_rdata),
    .dc_rdata_valid  (dc_rdata_valid),
    .mem_req_valid   (mem_req_valid),
    .mem_req_write   (mem_req_write),
    .mem_req_addr    (mem_req_addr),
    .mem_req_ready   (mem_req_ready),
    .mem_wdata       (mem_wdata),
    .mem_wdata_valid (mem_wdata_valid),
    .mem_wdata_ready (mem_wdata_ready),
    .mem_rdata       (mem_rdata),
    .mem_rdata_valid (mem_rdata_valid),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Arbitration rule: returns 1 when the D-cache should win.
  function automatic bit model_pick(input bit ic, input bit dc);
`ifdef MEM_ARB_FAIR_EN
    if (ic && dc) return !last_dc;
`endif
    return dc;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_ic_ready"},  ic_req_ready, 0);
    check({tag, "_dc_ready"},  dc_req_ready, 0);
    check({tag, "_mreq_v"},    mem_req_valid, 0);
    check({tag, "_mreq_w"},    mem_req_write, 0);
    check({tag, "_mreq_a"},    mem_req_addr, 0);
    check({tag, "_ic_rv"},     ic_rdata_valid, 0);
    check({tag, "_dc_rv"},     dc_rdata_valid, 0);
    check({tag, "_ic_rd"},     ic_rdata, 0);
    check({tag, "_dc_rd"},     dc_rdata, 0);
    check({tag, "_mwd_v"},     mem_wdata_valid, 0);
    check({tag, "_mwd"},       mem_wdata, 0);
    check({tag, "_dc_wrdy"},   dc_wdata_ready, 0);
  endtask

  // One full transaction starting in an IDLE cycle: grant, request phase with
  // 'stall' refused cycles, then LW beats (mode 0: every cycle with data
  // 0xA0+n, mode 1: handshake toggles 1,0,1..., mode 2: random handshake).
  task automatic serve(input int stall, input int mode);
    bit           win_dc, wr, v;
    logic [A-1:0] addr;
    logic [D-1:0] dat;
    int           beats, cyc;
    ic_req_valid    = ic_pend;
    ic_req_addr     = ic_a;
    dc_req_valid    = dc_pend;
    dc_req_addr     = dc_a;
    dc_req_write    = dc_w;
    mem_req_ready   = 1'b0;
    mem_wdata_ready = 1'b0;
    mem_rdata_valid = 1'($urandom_range(0, 1));
    settle();
    check("idle_busy", busy, 0);
    check("idle_mreq_v", mem_req_valid, 0);
    check("idle_ic_rv", ic_rdata_valid, 0);
    check("idle_dc_rv", dc_rdata_valid, 0);
    win_dc = model_pick(ic_pend, dc_pend);
    check("grant_ic_ready", ic_req_ready, !win_dc);
    check("grant_dc_ready", dc_req_ready, win_dc);
    addr    = win_dc ? dc_a : ic_a;
    wr      = win_dc ? dc_w : 1'b0;
    last_dc = win_dc;
    tick();
    // The winner withdraws and scribbles its address; the latched copy must hold.
    if (win_dc) begin
      dc_pend = 0; dc_req_valid = 0;
      dc_req_addr = A'($urandom); dc_req_write = 1'($urandom);
    end else begin
      ic_pend = 0; ic_req_valid = 0; ic_req_addr = A'($urandom);
    end
    for (int s = 0; s < stall; s++) begin
      mem_req_ready   = 1'b0;
      mem_rdata_valid = 1'b1;
      settle();
      check("stall_mreq_v", mem_req_valid, 1);
      check("stall_mreq_a", mem_req_addr, addr);
      check("stall_mreq_w", mem_req_write, wr);
      check("stall_busy", busy, 1);
      check("stall_ic_rv", ic_rdata_valid, 0);
      check("stall_dc_rv", dc_rdata_valid, 0);
      tick();
    end
    mem_req_ready   = 1'b1;
    mem_rdata_valid = 1'b0;
    settle();
    check("req_mreq_v", mem_req_valid, 1);
    check("req_mreq_a", mem_req_addr, addr);
    check("req_mreq_w", mem_req_write, wr);
    tick();
    mem_req_ready = 1'b0;
    beats = 0;
    cyc   = 0;
    while (beats < LW && cyc < 200) begin
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (cyc % 2 == 0);
      else                v = 1'($urandom_range(0, 1));
      dat      = (mode == 0) ? D'(32'hA0 + beats) : D'($urandom);
      dc_wdata = D'($urandom);
      if (wr) begin
        mem_wdata_ready = v;
        mem_rdata_valid = 1'($urandom_range(0, 1));
        mem_rdata       = D'($urandom);
      end else begin
        mem_rdata_valid = v;
        mem_rdata       = dat;
        mem_wdata_ready = 1'($urandom_range(0, 1));
      end
      settle();
      check("beat_busy", busy, 1);
      check("beat_mreq_v", mem_req_valid, 0);
      if (wr) begin
        check("wr_mwd_v", mem_wdata_valid, 1);
        check("wr_mwd", mem_wdata, dc_wdata);
        check("wr_dc_wrdy", dc_wdata_ready, v);
        check("wr_ic_rv", ic_rdata_valid, 0);
        check("wr_dc_rv", dc_rdata_valid, 0);
      end else begin
        check("rd_owner_rv", win_dc ? dc_rdata_valid : ic_rdata_valid, v);
        check("rd_other_rv", win_dc ? ic_rdata_valid : dc_rdata_valid, 0);
        if (v) check("rd_owner_rd", win_dc ? dc_rdata : ic_rdata, dat);
        check("rd_mwd_v", mem_wdata_valid, 0);
        check("rd_dc_wrdy", dc_wdata_ready, 0);
      end
      if (v) beats++;
      cyc++;
      tick();
    end
    check("burst_in_budget", beats, LW);
    // Right after the last beat the arbiter must be idle and ignore read beats.
    mem_wdata_ready = 1'b0;
    mem_rdata_valid = 1'b1;
    settle();
    check("post_busy", busy, 0);
    check("post_mreq_v", mem_req_valid, 0);
    check("post_ic_rv", ic_rdata_valid, 0);
    check("post_dc_rv", dc_rdata_valid, 0);
  endtask

  initial begin
    // Reset with every input active: all outputs must be quiet.
    rst_n           = 1'b0;
    ic_req_valid    = 1'b1;
    ic_req_addr     = A'($urandom);
    dc_req_valid    = 1'b1;
    dc_req_write    = 1'b1;
    dc_req_addr     = A'($urandom);
    dc_wdata        = D'($urandom);
    mem_req_ready   = 1'b1;
    mem_wdata_ready = 1'b1;
    mem_rdata       = D'($urandom);
    mem_rdata_valid = 1'b1;
    ic_pend = 0; dc_pend = 0; dc_w = 0; ic_a = '0; dc_a = '0; last_dc = 0;
    tick();
    tick();
    check_all_zero("reset");

    // Spurious read beat while idle.
    rst_n = 1'b1;
    ic_req_valid = 0; dc_req_valid = 0; mem_req_ready = 0; mem_wdata_ready = 0;
    mem_rdata_valid = 1'b1;
    tick();
    settle();
    check("spur_ic_rv", ic_rdata_valid, 0);
    check("spur_dc_rv", dc_rdata_valid, 0);
    check("spur_busy", busy, 0);

    // Single I-cache read to 0x10, beats 0xA0..0xA3.
    ic_pend = 1; ic_a = A'(26'h10);
    serve(0, 0);

    // Tie, then the loser, then another tie.
    ic_pend = 1; ic_a = A'(26'h40);
    dc_pend = 1; dc_a = A'(26'h50); dc_w = 0;
    serve(0, 2);
    serve(0, 2);
    ic_pend = 1; ic_a = A'(26'h41);
    dc_pend = 1; dc_a = A'(26'h51); dc_w = 0;
    serve(0, 0);
    serve(1, 2);

    // D-cache writeback to 0x22 with wdata_ready toggling.
    dc_pend = 1; dc_a = A'(26'h22); dc_w = 1;
    serve(0, 1);

    // Memory refuses the request for 5 cycles.
    dc_pend = 1; dc_a = A'(26'h3ABCDE); dc_w = 1;
    serve(5, 2);

    // Reset after 2 of 4 read beats.
    ic_req_valid = 1; ic_req_addr = A'(26'h33);
    dc_req_valid = 0;
    settle();
    check("rst_grant", ic_req_ready, 1);
    tick();
    ic_req_valid = 0;
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    for (int b = 0; b < 2; b++) begin
      mem_rdata_valid = 1; mem_rdata = D'(32'hB0 + b);
      tick();
    end
    mem_rdata_valid = 1; mem_rdata = D'(32'hB2);
    rst_n = 1'b0;
    ic_req_valid = 1;
    tick();
    settle();
    check_all_zero("midrst");
    rst_n = 1'b1;
    ic_req_valid = 0;
    last_dc = 0;
    ic_pend = 1; ic_a = A'(26'h12);
    serve(0, 0);

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      if (!ic_pend && !dc_pend) begin
        int unsigned r;
        r = $urandom_range(1, 3);
        if (r[0]) begin ic_pend = 1; ic_a = A'($urandom); end
        if (r[1]) begin dc_pend = 1; dc_a = A'($urandom); dc_w = 1'($urandom); end
      end
      serve(int'($urandom_range(0, 3)), 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
